// File: rtl/lutram_arb_pkg.sv
// Shared types for the two-port LUT RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lutram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

endpackage

// File: rtl/rr_burst_grant.sv
// Round-robin grant between two requesters with bounded bursts per owner.
// Latency: grant is combinational from valid and current state; state updates on posedge.
// Backpressure: a requester sees its grant only while it is valid; grants are suppressed in reset.
module rr_burst_grant
    import lutram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          ptr, ptr_nxt;
    logic          own;
    logic          take_vld;
    logic          take_port;
    logic          keep;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ARB_IDLE;
            count <= '0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // ptr always names the port that is not the current owner
    always_comb begin
        grant     = 2'b00;
        state_nxt = state;
        count_nxt = count;
        ptr_nxt   = ptr;
        own       = 1'b0;
        take_vld  = 1'b0;
        take_port = 1'b0;
        keep      = 1'b0;
        if (nrst) begin
            case (state)
                ARB_IDLE: begin
                    if (|valid) begin
                        take_vld  = 1'b1;
                        take_port = (&valid) ? ptr : valid[1];
                    end
                end
                ARB_OWN0, ARB_OWN1: begin
                    own = (state == ARB_OWN1);
                    if (valid[own] && (!valid[~own] || count < CNT_MAX)) begin
                        take_vld  = 1'b1;
                        take_port = own;
                        keep      = 1'b1;
                    end else if (valid[~own]) begin
                        take_vld  = 1'b1;
                        take_port = ~own;
                    end else begin
                        state_nxt = ARB_IDLE;
                        count_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ARB_IDLE;
                    count_nxt = '0;
                end
            endcase
            if (take_vld) begin
                grant[take_port] = 1'b1;
                state_nxt        = take_port ? ARB_OWN1 : ARB_OWN0;
                ptr_nxt          = ~take_port;
                count_nxt        = keep ? ((count == CNT_MAX) ? count : count + CNT_ONE) : CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/lutram_port_arbiter.sv
// Shares one sync-write/async-read LUT RAM between two requesters, one transfer per cycle.
// Latency: fixed 2 cycles from transfer to response pulse; memory ports driven in the cycle between.
// Backpressure: reqN_ready is combinational from both valids and arbiter state; no response stall.
module lutram_port_arbiter
    import lutram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 2,
    parameter int MAX_ADDRESS = 31,
    parameter int MAX_BURST   = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_err,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef struct packed {
        logic                  vld;
        logic                  port;
        logic                  we;
        logic                  err;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } pipe_t;

    logic [1:0]            grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  addr_oor;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    pipe_t                 pipe_d, pipe_q;

    rr_burst_grant #(
        .MAX_BURST(MAX_BURST)
    ) u_grant (
        .clk  (clk),
        .nrst (nrst),
        .valid({req1_valid, req0_valid}),
        .grant(grant)
    );

    assign req0_ready = grant[PORT0];
    assign req1_ready = grant[PORT1];

    always_comb begin
        sel_we    = req0_we;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (grant[PORT1]) begin
            sel_we    = req1_we;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    // When MAX_ADDRESS covers the whole address space the check disappears entirely
    if (MAX_ADDRESS >= (1 << ADDR_WIDTH) - 1) begin : g_full_range
        assign addr_oor = 1'b0;
    end else begin : g_range_check
        localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_ADDRESS);
        assign addr_oor = (sel_addr > MAX_A);
    end

    assign pipe_d = '{
        vld:   |grant,
        port:  grant[PORT1],
        we:    sel_we,
        err:   addr_oor,
        addr:  sel_addr,
        wdata: sel_wdata
    };

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // nrst gates the write strobe so an op caught by reset never commits
    assign mem_write_address = pipe_q.addr;
    assign mem_write_data    = pipe_q.wdata;
    assign mem_write_enable  = pipe_q.vld & pipe_q.we & ~pipe_q.err & nrst;
    assign mem_read_address  = pipe_q.addr;
    assign rsp_rdata_nxt     = pipe_q.err ? '0 : mem_read_data;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= pipe_q.vld & ~pipe_q.port;
            rsp1_valid <= pipe_q.vld & pipe_q.port;
            if (pipe_q.vld && !pipe_q.port) begin
                rsp0_rdata <= rsp_rdata_nxt;
                rsp0_err   <= pipe_q.err;
            end
            if (pipe_q.vld && pipe_q.port) begin
                rsp1_rdata <= rsp_rdata_nxt;
                rsp1_err   <= pipe_q.err;
            end
        end
    end

endmodule

// File: tb/tb_lutram_port_arbiter.sv
// Bench for lutram_port_arbiter: directed traffic with a reference memory and per-port scoreboards.
// The RAM itself is modelled here; responses are checked by a negedge monitor.
module tb_lutram_port_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 2;
    localparam int MAXA = 20;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          nrst;
    logic          req0_valid, req0_we, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_we, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] mem_write_address, mem_read_address;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          mem_write_enable;

    lutram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_ADDRESS(MAXA),
        .MAX_BURST  (MAXB)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .req0_valid       (req0_valid),
        .req0_we          (req0_we),
        .req0_addr        (req0_addr),
        .req0_wdata       (req0_wdata),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_we          (req1_we),
        .req1_addr        (req1_addr),
        .req1_wdata       (req1_wdata),
        .req1_ready       (req1_ready),
        .rsp0_valid       (rsp0_valid),
        .rsp0_rdata       (rsp0_rdata),
        .rsp0_err         (rsp0_err),
        .rsp1_valid       (rsp1_valid),
        .rsp1_rdata       (rsp1_rdata),
        .rsp1_err         (rsp1_err),
        .mem_write_address(mem_write_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data)
    );

    // LUT RAM environment: sync write, async read, preset to addr[1:0]
    logic [DW-1:0] ram [32];
    logic          ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 32; i++) ram[i] <= i[1:0];
            ram_init_done <= 1'b1;
        end else if (mem_write_enable === 1'b1) begin
            ram[mem_write_address] <= mem_write_data;
        end
    end
    assign mem_read_data = ram[mem_read_address];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } op_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    op_t  q0[$], q1[$];
    exp_t eq0[$], eq1[$];
    int   grant_log[$], grant_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   g0 = 0;
    int   g1 = 0;

    logic [DW-1:0] ref_mem [32];
    logic          ref_init = 1'b0;
    logic          last_we = 1'b0;
    int            last_cyc = 0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_old;
    logic [DW-1:0] last_rsp1_rdata = '0;
    logic          last_rsp1_err = 1'b0;
    exp_t          mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_xfer(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t x;
        x.cyc = cyc;
        if (a > MAXA) begin
            x.err   = 1'b1;
            x.rdata = '0;
            last_we = 1'b0;
        end else begin
            x.err     = 1'b0;
            x.rdata   = ref_mem[a];
            last_we   = we;
            last_cyc  = cyc;
            last_addr = a;
            last_old  = ref_mem[a];
            if (we) ref_mem[a] = wd;
        end
        if (p == 0) eq0.push_back(x);
        else        eq1.push_back(x);
        grant_log.push_back(p);
        grant_cyc.push_back(cyc);
    endtask

    // Monitor: check responses, then record any transfer happening at the coming edge
    always @(negedge clk) begin
        if (!nrst) begin
            if (!ref_init) begin
                for (int i = 0; i < 32; i++) ref_mem[i] = i[1:0];
                ref_init = 1'b1;
            end
            // a write transferred last cycle must not commit once reset is seen
            if (last_we && last_cyc == cyc - 1) ref_mem[last_addr] = last_old;
            last_we = 1'b0;
            eq0.delete();
            eq1.delete();
        end else begin
            if (rsp0_valid) begin
                if (eq0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = eq0.pop_front();
                    chk("rsp0_rdata", 32'(rsp0_rdata), 32'(mon_e.rdata));
                    chk("rsp0_err", 32'(rsp0_err), 32'(mon_e.err));
                    chk("rsp0_latency", cyc - mon_e.cyc, 32'd2);
                end
            end
            if (rsp1_valid) begin
                last_rsp1_rdata = rsp1_rdata;
                last_rsp1_err   = rsp1_err;
                if (eq1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = eq1.pop_front();
                    chk("rsp1_rdata", 32'(rsp1_rdata), 32'(mon_e.rdata));
                    chk("rsp1_err", 32'(rsp1_err), 32'(mon_e.err));
                    chk("rsp1_latency", cyc - mon_e.cyc, 32'd2);
                end
            end
            chk("double_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (mem_write_enable) chk("write_in_range", 32'(mem_write_address <= MAXA), 32'd1);
            if (req0_valid && req0_ready)      note_xfer(0, req0_we, req0_addr, req0_wdata);
            else if (req1_valid && req1_ready) note_xfer(1, req1_we, req1_addr, req1_wdata);
        end
    end

    task automatic load0();
        op_t o;
        if (!req0_valid && q0.size() > 0) begin
            if (g0 < q0[0].gap) g0++;
            else begin
                o = q0.pop_front();
                req0_valid = 1'b1; req0_we = o.we; req0_addr = o.addr; req0_wdata = o.wdata;
                g0 = 0;
            end
        end
    endtask

    task automatic load1();
        op_t o;
        if (!req1_valid && q1.size() > 0) begin
            if (g1 < q1[0].gap) g1++;
            else begin
                o = q1.pop_front();
                req1_valid = 1'b1; req1_we = o.we; req1_addr = o.addr; req1_wdata = o.wdata;
                g1 = 0;
            end
        end
    endtask

    // Entered and left just after a posedge; valid held until its transfer
    task automatic run_traffic(input int max_cyc);
        int n;
        bit d0, d1;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid) && n < max_cyc) begin
            load0();
            load1();
            @(negedge clk);
            d0 = req0_valid && req0_ready;
            d1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (d0) req0_valid = 1'b0;
            if (d1) req1_valid = 1'b0;
            n++;
        end
        chk("traffic_timeout", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        chk("drain_port0", eq0.size(), 32'd0);
        chk("drain_port1", eq1.size(), 32'd0);
    endtask

    task automatic do_reset(input int n);
        nrst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic clear_log();
        grant_log.delete();
        grant_cyc.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        @(posedge clk); #1;

        // 1: both valid writes held through reset; nothing may move, port0 wins after release
        q0.push_back('{we: 1'b1, addr: 5'd3, wdata: 2'd1, gap: 0});
        q1.push_back('{we: 1'b1, addr: 5'd4, wdata: 2'd2, gap: 0});
        load0();
        load1();
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 32'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                                      rsp0_rdata, rsp1_rdata, mem_write_enable, mem_write_address,
                                      mem_write_data, mem_read_address}), 32'd0);
        end
        @(posedge clk); #1;
        clear_log();
        nrst = 1'b1;
        run_traffic(20);
        drain();
        chk("t1_grant_count", grant_log.size(), 32'd2);
        if (grant_log.size() > 0) chk("t1_first_grant", grant_log[0], 32'd0);

        // 2: port1 write 5<=2'b10 then read 5 on the next cycle
        clear_log();
        q1.push_back('{we: 1'b1, addr: 5'd5, wdata: 2'b10, gap: 0});
        q1.push_back('{we: 1'b0, addr: 5'd5, wdata: 2'b00, gap: 0});
        run_traffic(20);
        drain();
        chk("t2_raw_rdata", 32'(last_rsp1_rdata), 32'd2);
        chk("t2_raw_err", 32'(last_rsp1_err), 32'd0);
        if (grant_cyc.size() == 2) chk("t2_back_to_back", grant_cyc[1] - grant_cyc[0], 32'd1);
        else chk("t2_grant_count", grant_cyc.size(), 32'd2);

        // 3: both ports stream reads; bursts of four alternate with no gaps
        do_reset(2);
        clear_log();
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{we: 1'b0, addr: 5'(i), wdata: 2'd0, gap: 0});
            q1.push_back('{we: 1'b0, addr: 5'(i + 8), wdata: 2'd0, gap: 0});
        end
        run_traffic(60);
        drain();
        chk("t3_grant_count", grant_log.size(), 32'd16);
        for (int i = 0; i < 16 && i < grant_log.size(); i++)
            chk($sformatf("t3_grant[%0d]", i), grant_log[i], 32'((i / 4) % 2));
        if (grant_cyc.size() == 16) chk("t3_no_idle", grant_cyc[15] - grant_cyc[0], 32'd15);

        // 4: addresses above 20 are rejected; 20 itself is accepted
        q0.push_back('{we: 1'b1, addr: 5'd25, wdata: 2'd3, gap: 0});
        q0.push_back('{we: 1'b0, addr: 5'd25, wdata: 2'd0, gap: 0});
        q1.push_back('{we: 1'b0, addr: 5'd21, wdata: 2'd0, gap: 0});
        q1.push_back('{we: 1'b1, addr: 5'd20, wdata: 2'd3, gap: 0});
        q1.push_back('{we: 1'b0, addr: 5'd20, wdata: 2'd0, gap: 0});
        run_traffic(30);
        drain();
        chk("t4_boundary_rdata", 32'(last_rsp1_rdata), 32'd3);

        // 5: write 7<=0 accepted, reset the very next cycle; addr 7 keeps its preset 3
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd7; req0_wdata = 2'd0;
        @(negedge clk);
        chk("t5_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        q1.push_back('{we: 1'b0, addr: 5'd7, wdata: 2'd0, gap: 0});
        run_traffic(20);
        drain();
        chk("t5_no_commit", 32'(last_rsp1_rdata), 32'd3);

        // 6: random mixed traffic, then read everything back and compare the RAM itself
        for (int i = 0; i < 40; i++) begin
            q0.push_back('{we: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 22)),
                           wdata: 2'($urandom_range(0, 3)), gap: int'($urandom_range(0, 2))});
            q1.push_back('{we: 1'($urandom_range(0, 1)), addr: 5'($urandom_range(0, 22)),
                           wdata: 2'($urandom_range(0, 3)), gap: int'($urandom_range(0, 2))});
        end
        run_traffic(1000);
        drain();
        for (int a = 0; a <= MAXA; a++)
            q1.push_back('{we: 1'b0, addr: 5'(a), wdata: 2'd0, gap: 0});
        run_traffic(100);
        drain();
        for (int a = 0; a < 32; a++)
            chk($sformatf("mem[%0d]", a), 32'(ram[a]), 32'(ref_mem[a]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
